// File: rtl/bank_regs.sv
// Bank-register unit: EB/FB/BB registers on a request/acknowledge bus plus the
// super-bank bit loaded from I/O channel 7. All outputs are registered.
module bank_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  input  logic        chan_we,
  input  logic [8:0]  chan_addr,
  input  logic [15:0] chan_wdata,
  output logic [2:0]  eBank,
  output logic [4:0]  fBank,
  output logic        superBank
);

  typedef enum logic {StIdle, StAck} busState_t;

  busState_t   stateQ, stateD;
  logic        accept;
  logic        isEb, isFb, isBb, unmapped;
  logic [15:0] readWord;
  logic [2:0]  eBankQ;
  logic [4:0]  fBankQ;
  logic        superBankQ;
  logic [15:0] rdataQ;
  logic        errQ;

  assign isEb     = (addr == 12'd3);
  assign isFb     = (addr == 12'd4);
  assign isBb     = (addr == 12'd6);
  assign unmapped = !(isEb || isFb || isBb);

  always_comb begin
    stateD = stateQ;
    accept = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (req) begin
          stateD = StAck;
          accept = 1'b1;
        end
      end
      StAck:   stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    readWord = 16'h0000;
    if (isEb) begin
      readWord[10:8] = eBankQ;
    end else if (isFb) begin
      readWord[14:10] = fBankQ;
    end else if (isBb) begin
      readWord[14:10] = fBankQ;
      readWord[2:0]   = eBankQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= StIdle;
      eBankQ     <= 3'd0;
      fBankQ     <= 5'd0;
      superBankQ <= 1'b0;
      rdataQ     <= 16'h0000;
      errQ       <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        if (we) begin
          if (isEb || isBb) begin
            eBankQ <= isEb ? wdata[10:8] : wdata[2:0];
          end
          if (isFb || isBb) begin
            fBankQ <= wdata[14:10];
          end
        end
        // Read data is captured at accept so rdata is a flop, never a decode of addr.
        rdataQ <= (we || unmapped) ? 16'h0000 : readWord;
        errQ   <= unmapped;
      end else begin
        rdataQ <= 16'h0000;
        errQ   <= 1'b0;
      end
      if (chan_we && chan_addr == 9'd7) begin
        superBankQ <= chan_wdata[6];
      end
    end
  end

  assign ready     = (stateQ == StIdle);
  assign ack       = (stateQ == StAck);
  assign err       = errQ;
  assign rdata     = rdataQ;
  assign eBank     = eBankQ;
  assign fBank     = fBankQ;
  assign superBank = superBankQ;

endmodule

// File: tb/tb_bank_regs.sv
// Bench for bank_regs: directed vector table, hand-written multi-cycle sequences
// and randomized transactions checked against a field-level reference model.
module tb_bank_regs;

  logic        clk = 1'b0;
  logic        reset, req, we, chan_we;
  logic [11:0] addr;
  logic [15:0] wdata, chan_wdata;
  logic [8:0]  chan_addr;
  logic        ready, ack, err, superBank;
  logic [15:0] rdata;
  logic [2:0]  eBank;
  logic [4:0]  fBank;

  int checks = 0;
  int failures = 0;

  // Reference model: the architectural bank fields.
  int mEb, mFb, mSb;

  bank_regs dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .chan_we    (chan_we),
    .chan_addr  (chan_addr),
    .chan_wdata (chan_wdata),
    .eBank      (eBank),
    .fBank      (fBank),
    .superBank  (superBank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [15:0] d;
    logic        expErr;
    logic [15:0] expRdata;
    logic [2:0]  expEb;
    logic [4:0]  expFb;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] modelRead(input int a);
    if (a == 3) return 16'((mEb % 8) * 256);
    if (a == 4) return 16'((mFb % 32) * 1024);
    if (a == 6) return 16'((mFb % 32) * 1024 + (mEb % 8));
    return 16'h0000;
  endfunction

  function automatic void modelWrite(input int a, input int d);
    if (a == 3) mEb = (d / 256) % 8;
    if (a == 4) mFb = (d / 1024) % 32;
    if (a == 6) begin
      mFb = (d / 1024) % 32;
      mEb = d % 8;
    end
  endfunction

  // One bus transaction from IDLE, optional concurrent channel write; checks the ack cycle.
  task automatic xfer(input logic w, input logic [11:0] a, input logic [15:0] d,
                      input logic cw, input logic [8:0] ca, input logic [15:0] cd,
                      input logic expErr, input logic [15:0] expRd, input logic chkRd,
                      input logic [2:0] expEb, input logic [4:0] expFb,
                      input logic expSb, input string tag);
    chk({tag, ".ready"}, 16'(ready), 16'd1);
    req = 1'b1; we = w; addr = a; wdata = d;
    chan_we = cw; chan_addr = ca; chan_wdata = cd;
    tick();
    req = 1'b0; chan_we = 1'b0;
    chk({tag, ".ack"}, 16'(ack), 16'd1);
    chk({tag, ".err"}, 16'(err), 16'(expErr));
    if (chkRd) chk({tag, ".rdata"}, rdata, expRd);
    chk({tag, ".eBank"}, 16'(eBank), 16'(expEb));
    chk({tag, ".fBank"}, 16'(fBank), 16'(expFb));
    chk({tag, ".superBank"}, 16'(superBank), 16'(expSb));
    tick();
    chk({tag, ".ackDrop"}, 16'(ack), 16'd0);
    chk({tag, ".rdataIdle"}, rdata, 16'h0000);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    chan_we = 1'b0; chan_addr = '0; chan_wdata = '0;
    mEb = 0; mFb = 0; mSb = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset.ready", 16'(ready), 16'd1);
    chk("reset.ack", 16'(ack), 16'd0);
    chk("reset.err", 16'(err), 16'd0);
    chk("reset.rdata", rdata, 16'h0000);
    chk("reset.banks", {8'(eBank), 7'(fBank), superBank}, 16'h0000);

    vecs[0]  = '{1'b0, 12'd3, 16'h0000, 1'b0, 16'h0000, 3'd0, 5'd0};
    vecs[1]  = '{1'b0, 12'd4, 16'h0000, 1'b0, 16'h0000, 3'd0, 5'd0};
    vecs[2]  = '{1'b0, 12'd6, 16'h0000, 1'b0, 16'h0000, 3'd0, 5'd0};
    vecs[3]  = '{1'b1, 12'd6, 16'h6405, 1'b0, 16'h0000, 3'b101, 5'b11001};
    vecs[4]  = '{1'b0, 12'd3, 16'h0000, 1'b0, 16'h0500, 3'b101, 5'b11001};
    vecs[5]  = '{1'b0, 12'd4, 16'h0000, 1'b0, 16'h6400, 3'b101, 5'b11001};
    vecs[6]  = '{1'b0, 12'd6, 16'h0000, 1'b0, 16'h6405, 3'b101, 5'b11001};
    vecs[7]  = '{1'b1, 12'd5, 16'hFFFF, 1'b1, 16'h0000, 3'b101, 5'b11001};
    vecs[8]  = '{1'b0, 12'd5, 16'h0000, 1'b1, 16'h0000, 3'b101, 5'b11001};
    vecs[9]  = '{1'b1, 12'd3, 16'h0200, 1'b0, 16'h0000, 3'd2, 5'b11001};
    vecs[10] = '{1'b0, 12'd6, 16'h0000, 1'b0, 16'h6402, 3'd2, 5'b11001};
    vecs[11] = '{1'b1, 12'd4, 16'h7C00, 1'b0, 16'h0000, 3'd2, 5'd31};

    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, 9'd0, 16'h0, vecs[i].expErr,
           vecs[i].expRdata, !vecs[i].w || vecs[i].expErr, vecs[i].expEb, vecs[i].expFb,
           1'b0, $sformatf("vec%0d", i));
      if (vecs[i].w) modelWrite(int'(vecs[i].a), int'(vecs[i].d));
    end

    // Channel writes: channel 7 sets, other channels ignored, later write wins.
    chan_we = 1'b1; chan_addr = 9'd7; chan_wdata = 16'h0040;
    tick();
    chan_we = 1'b0;
    chk("chan7.set", 16'(superBank), 16'd1);
    chan_we = 1'b1; chan_addr = 9'd5; chan_wdata = 16'h0000;
    tick();
    chan_we = 1'b0;
    chk("chan5.ignored", 16'(superBank), 16'd1);
    chan_we = 1'b1; chan_addr = 9'd7; chan_wdata = 16'h0040;
    tick();
    chan_wdata = 16'h0000;
    tick();
    chan_we = 1'b0;
    chk("chan7.laterWins", 16'(superBank), 16'd0);

    // Held req: alternating EB writes, ack every second cycle.
    req = 1'b1; we = 1'b1; addr = 12'd3; wdata = 16'h0100;
    for (int k = 0; k < 4; k++) begin
      logic expAck;
      tick();
      expAck = (k % 2 == 0);
      if (expAck) mEb = (k == 0) ? 1 : 7;
      chk($sformatf("held%0d.ack", k), 16'(ack), 16'(expAck));
      chk($sformatf("held%0d.ready", k), 16'(ready), 16'(!expAck));
      chk($sformatf("held%0d.eBank", k), 16'(eBank), 16'(mEb));
      if (expAck) wdata = 16'h0700;
    end
    req = 1'b0;
    tick();
    chk("held.idle", 16'(ack), 16'd0);

    // Bus FB write and channel-7 write in the same cycle.
    xfer(1'b1, 12'd4, 16'h7000, 1'b1, 9'd7, 16'h0040, 1'b0, 16'h0, 1'b0,
         3'(mEb), 5'b11100, 1'b1, "simul");
    mFb = 28; mSb = 1;

    // Reset during the ACK cycle of a write.
    req = 1'b1; we = 1'b1; addr = 12'd6; wdata = 16'h1234;
    tick();
    req = 1'b0;
    chk("rstAck.ackBefore", 16'(ack), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstAck.ack", 16'(ack), 16'd0);
    chk("rstAck.ready", 16'(ready), 16'd1);
    chk("rstAck.banks", {8'(eBank), 7'(fBank), superBank}, 16'h0000);
    tick();
    chk("rstAck.noLateAck", 16'(ack), 16'd0);

    // Write presented while reset is high is discarded.
    reset = 1'b1; req = 1'b1; we = 1'b1; addr = 12'd6; wdata = 16'h7C07;
    tick();
    reset = 1'b0; req = 1'b0;
    chk("rstWr.ack", 16'(ack), 16'd0);
    chk("rstWr.banks", {8'(eBank), 7'(fBank), superBank}, 16'h0000);
    tick();
    chk("rstWr.noAck", 16'(ack), 16'd0);
    mEb = 0; mFb = 0; mSb = 0;

    // Randomized transactions against the model.
    for (int i = 0; i < 200; i++) begin
      int sel, a, d, ca, cd;
      logic w, cw, mapped;
      logic [15:0] expRd;
      sel = int'($urandom_range(0, 3));
      a   = (sel == 0) ? 3 : (sel == 1) ? 4 : (sel == 2) ? 6 : int'($urandom_range(0, 4095));
      d   = int'($urandom_range(0, 65535));
      w   = 1'($urandom_range(0, 1));
      cw  = 1'($urandom_range(0, 1));
      ca  = ($urandom_range(0, 1) == 1) ? 7 : int'($urandom_range(0, 511));
      cd  = int'($urandom_range(0, 65535));
      mapped = (a == 3 || a == 4 || a == 6);
      expRd = (w || !mapped) ? 16'h0000 : modelRead(a);
      if (w) modelWrite(a, d);
      if (cw && ca == 7) mSb = (cd / 64) % 2;
      xfer(w, 12'(a), 16'(d), cw, 9'(ca), 16'(cd), !mapped, expRd, !w || !mapped,
           3'(mEb), 5'(mFb), 1'(mSb), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bank_regs.md
# bank_regs

Bank-register unit for the memory path: holds the erasable bank (EB), fixed bank (FB) and super-bank bit, and drives the `eBank`/`fBank`/`superBank` inputs of the memory address translator. The sequencer writes and reads the bank registers over a request/acknowledge bus. The super-bank bit is set by I/O channel 7 writes. This is the write side of the bank fields that the address translator consumes.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  bus request; held until `ack` is seen.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  12  register address: 3 = EB, 4 = FB, 6 = BB.
- `wdata`  in  16  write data.
- `ready`  out  1  high when idle; a request is accepted when `req && ready`.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `ack`; 1 = unmapped address.
- `rdata`  out  16  read data, valid only while `ack` = 1; 0 otherwise.
- `chan_we`  in  1  I/O channel write strobe, single cycle, no handshake.
- `chan_addr`  in  9  channel number; only 7 is decoded.
- `chan_wdata`  in  16  channel data; bit 6 is the super-bank bit.
- `eBank`  out  3  current erasable bank.
- `fBank`  out  5  current fixed bank.
- `superBank`  out  1  current super-bank bit.

## Operation
- Register word layouts (all unused bits read as 0):
  - EB word: `eBank` in [10:8].
  - FB word: `fBank` in [14:10].
  - BB word: `fBank` in [14:10] and `eBank` in [2:0].
- Writes:
  - EB write updates `eBank` only.
  - FB write updates `fBank` only.
  - BB write updates both fields atomically.
  - An FB write is therefore visible through BB, and vice versa.
- Reads return the layout above for the current register values.
- Unmapped address (anything other than 3, 4 or 6):
  - `ack` = 1, `err` = 1, `rdata` = 0.
  - No register changes, whether read or write.
- Channel writes:
  - `chan_we && chan_addr == 7` loads `superBank <= chan_wdata[6]`.
  - Any other channel number is ignored.
- State machine, two states:
  - IDLE: `ready` = 1. On `req`, capture `we`/`addr`/`wdata` and go to ACK.
  - ACK: `ready` = 0, `ack` = 1. The write takes effect at the IDLE→ACK edge. Always returns to IDLE on the next edge.
- `req` high during ACK is not a new request. A held `req` is accepted again only in the following IDLE cycle, so back-to-back transactions take 2 cycles each.

## Timing
- Reset values:
  - `eBank` = 0, `fBank` = 0, `superBank` = 0.
  - State IDLE: `ready` = 1, `ack` = 0, `err` = 0, `rdata` = 0.
- Latency:
  - Request accepted in cycle N; `ack`/`rdata`/`err` asserted in cycle N+1.
  - A written value is visible on the bank outputs from cycle N+1, the same cycle as `ack`.
- Read of a register written by the previous transaction returns the new value.
- Simultaneous events:
  - A channel-7 write in the same cycle as a bus write to any register: both apply; the fields are independent.
  - Two channel-7 writes in consecutive cycles: the later value wins.
- Reset asserted in ACK: the next edge forces IDLE and reset values. No `ack` appears in the following cycle. A write accepted in the same cycle that reset is high is discarded.
- Outputs are registered. No combinational path from `req`/`addr` to any output.

## Test plan
- Reset, then read EB, FB and BB: each returns `rdata` = 0x0000 with `ack` on cycle N+1 and `err` = 0. Bank outputs are all 0.
- Write BB with `wdata` = 0x6405: `fBank` = 5'b11001 and `eBank` = 3'b101 on the `ack` cycle. Reading EB then returns 0x0500; reading FB returns 0x6400.
- Channel write, `chan_addr` = 7, `chan_wdata` = 0x0040:
  - `superBank` = 1 next cycle.
  - With the BB value above, translator address 12'b010000000000 maps to 16'b1000010000000000.
  - `chan_addr` = 5 with the same data leaves `superBank` unchanged.
- Write to `addr` = 5 with 0xFFFF: `ack` = 1, `err` = 1, `rdata` = 0, all bank outputs unchanged.
- Hold `req` high with alternating EB writes 0x0100 and 0x0700: `ack` on every second cycle, `ready` low during `ack`, `eBank` steps 1 → 7.
- Same cycle: FB write 0x7000 (accepted) and channel-7 write 0x0040. Next cycle: `fBank` = 5'b11100 and `superBank` = 1. Reset asserted during the ACK cycle of a following write returns everything to 0 and suppresses any further `ack`.
